// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU function codes and forwarding-select encoding for the ID/EX stage.
// The optional forwarding datapath is selected by the ID_EX_FORWARDING_EN macro in id_ex_stage.
package id_ex_stage_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;
  localparam int FWIDTH_DEF = 4;

  localparam logic [FWIDTH_DEF-1:0] ALU_ADD = 4'd0;
  localparam logic [FWIDTH_DEF-1:0] ALU_SUB = 4'd1;
  localparam logic [FWIDTH_DEF-1:0] ALU_AND = 4'd2;
  localparam logic [FWIDTH_DEF-1:0] ALU_OR  = 4'd3;
  localparam logic [FWIDTH_DEF-1:0] ALU_SLT = 4'd4;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding: compares one source register against the EX/MEM and MEM/WB
// destinations and muxes the newest value. The younger EX/MEM result wins; $0 never matches.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [DWIDTH-1:0] src_data,
  input  logic              exmem_reg_wr,
  input  logic [AWIDTH-1:0] exmem_addr,
  input  logic [DWIDTH-1:0] exmem_data,
  input  logic              memwb_reg_wr,
  input  logic [AWIDTH-1:0] memwb_addr,
  input  logic [DWIDTH-1:0] memwb_data,
  output logic [1:0]        sel,
  output logic [DWIDTH-1:0] data
);

  fwd_sel_t sel_e;

  always_comb begin
    sel_e = FWD_REG;
    if (exmem_reg_wr && (exmem_addr != '0) && (exmem_addr == src_addr)) begin
      sel_e = FWD_EXMEM;
    end else if (memwb_reg_wr && (memwb_addr != '0) && (memwb_addr == src_addr)) begin
      sel_e = FWD_MEMWB;
    end
  end

  always_comb begin
    data = src_data;
    case (sel_e)
      FWD_EXMEM: data = exmem_data;
      FWD_MEMWB: data = memwb_data;
      default:   data = src_data;
    endcase
  end

  assign sel = sel_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and hazard stall.
// ID_EX_FORWARDING_EN: defined -> forward and stall on load-use only; undefined -> stall on any RAW.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int FWIDTH = FWIDTH_DEF
) (
  input  logic              ie_i_clk,
  input  logic              ie_i_rst,
  input  logic              ie_i_valid,
  input  logic [DWIDTH-1:0] ie_i_data_rs,
  input  logic [DWIDTH-1:0] ie_i_data_rt,
  input  logic [AWIDTH-1:0] ie_i_addr_rs,
  input  logic [AWIDTH-1:0] ie_i_addr_rt,
  input  logic [AWIDTH-1:0] ie_i_addr_rd,
  input  logic [DWIDTH-1:0] ie_i_imm,
  input  logic [FWIDTH-1:0] ie_i_funct,
  input  logic              ie_i_alu_src,
  input  logic              ie_i_reg_wr,
  input  logic              ie_i_mem_rd,
  input  logic              ie_i_mem_wr,
  input  logic              ie_i_flush,
  input  logic              ie_i_exmem_reg_wr,
  input  logic [AWIDTH-1:0] ie_i_exmem_addr_rd,
  input  logic [DWIDTH-1:0] ie_i_exmem_data,
  input  logic              ie_i_memwb_reg_wr,
  input  logic [AWIDTH-1:0] ie_i_memwb_addr_rd,
  input  logic [DWIDTH-1:0] ie_i_memwb_data,
  output logic              ie_o_stall,
  output logic              ie_o_valid,
  output logic [DWIDTH-1:0] ie_o_alu_a,
  output logic [DWIDTH-1:0] ie_o_alu_b,
  output logic [FWIDTH-1:0] ie_o_funct,
  output logic [DWIDTH-1:0] ie_o_store_data,
  output logic [AWIDTH-1:0] ie_o_addr_rd,
  output logic              ie_o_reg_wr,
  output logic              ie_o_mem_rd,
  output logic              ie_o_mem_wr
);

  logic              valid_q;
  logic [DWIDTH-1:0] data_rs_q;
  logic [DWIDTH-1:0] data_rt_q;
  logic [AWIDTH-1:0] addr_rs_q;
  logic [AWIDTH-1:0] addr_rt_q;
  logic [AWIDTH-1:0] addr_rd_q;
  logic [DWIDTH-1:0] imm_q;
  logic [FWIDTH-1:0] funct_q;
  logic              alu_src_q;
  logic              reg_wr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;

  logic              load_use;
  logic [1:0]        sel_rs;
  logic [1:0]        sel_rt;
  logic [DWIDTH-1:0] opnd_rs;
  logic [DWIDTH-1:0] opnd_rt;

  // Bubbles only clear the qualifying bits; datapath fields keep their old value.
  always_ff @(posedge ie_i_clk) begin
    if (!ie_i_rst) begin
      valid_q   <= 1'b0;
      data_rs_q <= '0;
      data_rt_q <= '0;
      addr_rs_q <= '0;
      addr_rt_q <= '0;
      addr_rd_q <= '0;
      imm_q     <= '0;
      funct_q   <= '0;
      alu_src_q <= 1'b0;
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
    end else if (ie_i_flush || ie_o_stall) begin
      valid_q  <= 1'b0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      valid_q   <= ie_i_valid;
      data_rs_q <= ie_i_data_rs;
      data_rt_q <= ie_i_data_rt;
      addr_rs_q <= ie_i_addr_rs;
      addr_rt_q <= ie_i_addr_rt;
      addr_rd_q <= ie_i_addr_rd;
      imm_q     <= ie_i_imm;
      funct_q   <= ie_i_funct;
      alu_src_q <= ie_i_alu_src;
      reg_wr_q  <= ie_i_reg_wr & ie_i_valid;
      mem_rd_q  <= ie_i_mem_rd & ie_i_valid;
      mem_wr_q  <= ie_i_mem_wr & ie_i_valid;
    end
  end

  assign load_use = ie_i_valid & valid_q & mem_rd_q & (addr_rd_q != '0) &
                    ((addr_rd_q == ie_i_addr_rs) | (addr_rd_q == ie_i_addr_rt));

`ifdef ID_EX_FORWARDING_EN
  fwd_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_rs (
    .src_addr(addr_rs_q), .src_data(data_rs_q),
    .exmem_reg_wr(ie_i_exmem_reg_wr), .exmem_addr(ie_i_exmem_addr_rd), .exmem_data(ie_i_exmem_data),
    .memwb_reg_wr(ie_i_memwb_reg_wr), .memwb_addr(ie_i_memwb_addr_rd), .memwb_data(ie_i_memwb_data),
    .sel(sel_rs), .data(opnd_rs)
  );

  fwd_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_rt (
    .src_addr(addr_rt_q), .src_data(data_rt_q),
    .exmem_reg_wr(ie_i_exmem_reg_wr), .exmem_addr(ie_i_exmem_addr_rd), .exmem_data(ie_i_exmem_data),
    .memwb_reg_wr(ie_i_memwb_reg_wr), .memwb_addr(ie_i_memwb_addr_rd), .memwb_data(ie_i_memwb_data),
    .sel(sel_rt), .data(opnd_rt)
  );

  logic unused_sel;
  assign unused_sel = ^{sel_rs, sel_rt};

  assign ie_o_stall = load_use;
`else
  // Without forwarding the compare units look at the incoming decode sources instead,
  // so a hit against EX/MEM or MEM/WB means decode must wait for write-back.
  logic [DWIDTH-1:0] unused_fwd_rs;
  logic [DWIDTH-1:0] unused_fwd_rt;
  logic              raw_rs;
  logic              raw_rt;
  logic              unused_bits;

  fwd_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_rs (
    .src_addr(ie_i_addr_rs), .src_data(data_rs_q),
    .exmem_reg_wr(ie_i_exmem_reg_wr), .exmem_addr(ie_i_exmem_addr_rd), .exmem_data(ie_i_exmem_data),
    .memwb_reg_wr(ie_i_memwb_reg_wr), .memwb_addr(ie_i_memwb_addr_rd), .memwb_data(ie_i_memwb_data),
    .sel(sel_rs), .data(unused_fwd_rs)
  );

  fwd_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_rt (
    .src_addr(ie_i_addr_rt), .src_data(data_rt_q),
    .exmem_reg_wr(ie_i_exmem_reg_wr), .exmem_addr(ie_i_exmem_addr_rd), .exmem_data(ie_i_exmem_data),
    .memwb_reg_wr(ie_i_memwb_reg_wr), .memwb_addr(ie_i_memwb_addr_rd), .memwb_data(ie_i_memwb_data),
    .sel(sel_rt), .data(unused_fwd_rt)
  );

  assign raw_rs = (ie_i_addr_rs != '0) &
                  ((valid_q & reg_wr_q & (addr_rd_q == ie_i_addr_rs)) | (sel_rs != FWD_REG));
  assign raw_rt = (ie_i_addr_rt != '0) &
                  ((valid_q & reg_wr_q & (addr_rd_q == ie_i_addr_rt)) | (sel_rt != FWD_REG));

  assign opnd_rs     = data_rs_q;
  assign opnd_rt     = data_rt_q;
  assign unused_bits = ^{unused_fwd_rs, unused_fwd_rt, addr_rs_q, addr_rt_q};
  assign ie_o_stall  = load_use | (ie_i_valid & (raw_rs | raw_rt));
`endif

  assign ie_o_valid      = valid_q;
  assign ie_o_alu_a      = opnd_rs;
  assign ie_o_store_data = opnd_rt;
  assign ie_o_alu_b      = alu_src_q ? imm_q : opnd_rt;
  assign ie_o_funct      = funct_q;
  assign ie_o_addr_rd    = addr_rd_q;
  assign ie_o_reg_wr     = reg_wr_q;
  assign ie_o_mem_rd     = mem_rd_q;
  assign ie_o_mem_wr     = mem_wr_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the MIPS core: captures decoded operands and control from the decode stage, applies EX/MEM and MEM/WB operand forwarding, selects the immediate, and drives the operands and 4-bit function code straight into the ALU. It also detects load-use hazards and issues a stall to decode, inserting a bubble into execute.

## Interface
- DWIDTH, 32, data/operand width
- AWIDTH, 5, register address width
- FWIDTH, 4, ALU function code width

- ie_i_clk  in  1  clock, rising edge
- ie_i_rst  in  1  synchronous reset, active-low
- ie_i_valid  in  1  decode slot holds a real instruction
- ie_i_data_rs / ie_i_data_rt  in  DWIDTH  register-file read data
- ie_i_addr_rs / ie_i_addr_rt / ie_i_addr_rd  in  AWIDTH  source and destination registers
- ie_i_imm  in  DWIDTH  sign/zero-extended immediate
- ie_i_funct  in  FWIDTH  ALU operation
- ie_i_alu_src  in  1  1 = operand B is immediate
- ie_i_reg_wr / ie_i_mem_rd / ie_i_mem_wr  in  1  control bits
- ie_i_flush  in  1  kill the instruction entering execute
- ie_i_exmem_reg_wr, ie_i_exmem_addr_rd [AWIDTH], ie_i_exmem_data [DWIDTH]  in  EX/MEM write-back source
- ie_i_memwb_reg_wr, ie_i_memwb_addr_rd [AWIDTH], ie_i_memwb_data [DWIDTH]  in  MEM/WB write-back source
- ie_o_stall  out  1  decode and PC must hold
- ie_o_valid  out  1  execute slot valid
- ie_o_alu_a / ie_o_alu_b  out  DWIDTH  to ALU a_i_data_rs / a_i_data_rt
- ie_o_funct  out  FWIDTH  to ALU a_i_funct
- ie_o_store_data  out  DWIDTH  forwarded rt, for stores
- ie_o_addr_rd  out  AWIDTH; ie_o_reg_wr, ie_o_mem_rd, ie_o_mem_wr  out  1

## Operation
- Registered fields: valid, data_rs, data_rt, addr_rs, addr_rt, addr_rd, imm, funct, alu_src, reg_wr, mem_rd, mem_wr.
- Each edge, priority: reset > flush > stall > load.
  - Flush: valid, reg_wr, mem_rd, mem_wr <= 0; other fields don't-care.
  - Stall (ie_o_stall=1): same bubble as flush; decode holds its inputs, re-presented next cycle.
  - Load: all fields <= inputs; control bits gated by ie_i_valid.
- Load-use hazard: ie_o_stall = ie_i_valid & valid & mem_rd & addr_rd != 0 & (addr_rd == ie_i_addr_rs | addr_rd == ie_i_addr_rt). Combinational. Flush and stall may coincide; flush result wins (identical bubble).
- Forwarding (combinational, per source operand): EX/MEM match (reg_wr, addr != 0, addr equal) takes priority, else MEM/WB match, else registered value. Register 0 never forwarded.
- ie_o_alu_a = fwd(rs); ie_o_store_data = fwd(rt); ie_o_alu_b = alu_src ? imm : fwd(rt).
- Control outputs are registered values; bubble yields ie_o_reg_wr=ie_o_mem_rd=ie_o_mem_wr=0.

## Timing
- Latency: decode inputs visible on outputs 1 cycle after the capturing edge.
- Forwarding path combinational from ie_i_exmem_*/ie_i_memwb_* to ALU operands, same cycle.
- Reset: all registered fields 0; ie_o_valid=0, ie_o_funct=0, ie_o_addr_rd=0, control outputs 0, ie_o_alu_a=ie_o_alu_b=ie_o_store_data=0 (absent forwarding matches, which cannot hit reg 0). ie_o_stall=0 while valid=0.
- Reset asserted mid-stall clears the stage; stall drops the following cycle.
- Stall lasts exactly one cycle for a single load-use pair (bubble clears mem_rd).

## Configuration
- ID_EX_FORWARDING_EN defined: forwarding muxes as above, stall only on load-use.
- Undefined: operands are raw registered values; ie_o_stall asserts for any RAW hazard: incoming valid source (nonzero) matching ID/EX addr_rd with reg_wr, or EX/MEM, or MEM/WB destination with its reg_wr. Bubble behaviour unchanged.

## Structure
- Shared package/header: DWIDTH, AWIDTH, FWIDTH defaults, ALU function code constants (ADD=0, SUB=1, AND=2, OR=3, SLT=4), forwarding select encoding (REG, EXMEM, MEMWB).
- One sub-module: fwd_unit (per-operand compare and 3:1 mux), instantiated twice.

## Test plan
- Reset low 2 cycles with ie_i_valid=1 -> ie_o_valid=0, all control outputs 0, ie_o_stall=0.
- Load rs=5 (data 5), rt=4 (data 4), funct=1, no matches -> next cycle ie_o_alu_a=5, ie_o_alu_b=4, ie_o_funct=1.
- Same with ie_i_exmem_reg_wr=1, addr_rd=rs, data=100 and memwb also addr rs data=200 -> ie_o_alu_a=100; with exmem off -> 200; with addr 0 -> no forward.
- lw $8 in stage, next instr reads $8 -> ie_o_stall=1 one cycle, following ie_o_valid=0 and mem_rd=0; retried instr then loads, stall=0.
- ie_i_flush=1 with ie_i_valid=1, reg_wr=1 -> next cycle ie_o_valid=0, ie_o_reg_wr=0; flush with stall -> bubble.
- alu_src=1, imm=0xFFFF_FFF0, rt forwarded 7 -> ie_o_alu_b=0xFFFF_FFF0, ie_o_store_data=7; macro undefined -> RAW on EX/MEM dest raises ie_o_stall.
